// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID pipeline register, 32x32 register file with write bypass,
// operand forwarding, and branch/jump resolution fed back to fetch.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clr,
    input  logic [31:0] F_Instr,
    input  logic [31:0] F_Pc,
    input  logic        W_WE,
    input  logic [4:0]  W_A3,
    input  logic [31:0] W_WD,
    input  logic [1:0]  FwdRsSel,
    input  logic [1:0]  FwdRtSel,
    input  logic [31:0] E_Fwd,
    input  logic [31:0] M_Fwd,
    output logic [31:0] D_Instr,
    output logic [31:0] D_Pc,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        Branch,
    output logic        Jump,
    output logic [31:0] PCBranch,
    output logic [31:0] PCJump
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] FnJr    = 6'b001000;

    logic [31:0] regs [32];
    logic [4:0]  rs, rt;
    logic [31:0] rs_grf, rt_grf;
    logic [5:0]  opcode, funct;
    logic        is_beq, is_bne, is_j, is_jal, is_jr;
    logic [31:0] br_offset;

    // IF/ID register: clr beats stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D_Instr <= NOP;
            D_Pc    <= RESET_PC;
        end else if (clr) begin
            D_Instr <= NOP;
            D_Pc    <= F_Pc;
        end else if (!stall) begin
            D_Instr <= F_Instr;
            D_Pc    <= F_Pc;
        end
    end

    // regs[0] is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (W_WE && (W_A3 != 5'd0)) begin
            regs[W_A3] <= W_WD;
        end
    end

    assign rs = D_Instr[25:21];
    assign rt = D_Instr[20:16];

    always_comb begin
        rs_grf = regs[rs];
        if (rs == 5'd0) begin
            rs_grf = '0;
        end else if (!reset && W_WE && (W_A3 == rs)) begin
            rs_grf = W_WD;
        end

        rt_grf = regs[rt];
        if (rt == 5'd0) begin
            rt_grf = '0;
        end else if (!reset && W_WE && (W_A3 == rt)) begin
            rt_grf = W_WD;
        end
    end

    always_comb begin
        case (FwdRsSel)
            2'd1:    RD1 = E_Fwd;
            2'd2:    RD1 = M_Fwd;
            default: RD1 = rs_grf;
        endcase
        case (FwdRtSel)
            2'd1:    RD2 = E_Fwd;
            2'd2:    RD2 = M_Fwd;
            default: RD2 = rt_grf;
        endcase
    end

    assign opcode = D_Instr[31:26];
    assign funct  = D_Instr[5:0];
    assign is_beq = (opcode == OpBeq);
    assign is_bne = (opcode == OpBne);
    assign is_j   = (opcode == OpJ);
    assign is_jal = (opcode == OpJal);
    assign is_jr  = (opcode == OpRtype) && (funct == FnJr);

    assign Branch = !stall && ((is_beq && (RD1 == RD2)) || (is_bne && (RD1 != RD2)));
    assign Jump   = !stall && (is_j || is_jal || is_jr);

    assign br_offset = {{14{D_Instr[15]}}, D_Instr[15:0], 2'b00};
    assign PCBranch  = D_Pc + 32'd4 + br_offset;
    assign PCJump    = is_jr ? RD1 : {D_Pc[31:28], D_Instr[25:0], 2'b00};

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, hand-written multi-cycle sequences,
// and a randomized run checked against an architectural model of the decode stage.
module tb_id_stage;

    logic        clk, reset, stall, clr;
    logic [31:0] F_Instr, F_Pc;
    logic        W_WE;
    logic [4:0]  W_A3;
    logic [31:0] W_WD;
    logic [1:0]  FwdRsSel, FwdRtSel;
    logic [31:0] E_Fwd, M_Fwd;
    logic [31:0] D_Instr, D_Pc, RD1, RD2, PCBranch, PCJump;
    logic        Branch, Jump;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr),
        .F_Instr(F_Instr), .F_Pc(F_Pc),
        .W_WE(W_WE), .W_A3(W_A3), .W_WD(W_WD),
        .FwdRsSel(FwdRsSel), .FwdRtSel(FwdRtSel),
        .E_Fwd(E_Fwd), .M_Fwd(M_Fwd),
        .D_Instr(D_Instr), .D_Pc(D_Pc), .RD1(RD1), .RD2(RD2),
        .Branch(Branch), .Jump(Jump), .PCBranch(PCBranch), .PCJump(PCJump)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc);
        F_Instr = instr;
        F_Pc    = pc;
        step();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        W_WE = 1'b1;
        W_A3 = a;
        W_WD = d;
        step();
        W_WE = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr, pc;
        logic [1:0]  rs_sel, rt_sel;
        logic [31:0] e_fwd, m_fwd;
        logic [31:0] rd1, rd2;
        logic        br, jp;
        logic [31:0] pcb, pcj;
        logic        chk_pcj;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [31:0] instr, input logic [31:0] pc,
                                input logic [1:0] rs_sel, input logic [1:0] rt_sel,
                                input logic [31:0] e_fwd, input logic [31:0] m_fwd,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic br, input logic jp,
                                input logic [31:0] pcb, input logic [31:0] pcj,
                                input logic chk_pcj);
        vec_t v;
        v.name = name; v.instr = instr; v.pc = pc; v.rs_sel = rs_sel; v.rt_sel = rt_sel;
        v.e_fwd = e_fwd; v.m_fwd = m_fwd; v.rd1 = rd1; v.rd2 = rd2; v.br = br; v.jp = jp;
        v.pcb = pcb; v.pcj = pcj; v.chk_pcj = chk_pcj;
        return v;
    endfunction

    // Architectural model state for the randomized phase
    logic [31:0] m_regs [32];
    logic [31:0] m_instr, m_pc;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (W_WE && W_A3 == a) return W_WD;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_sel(input logic [1:0] s, input logic [31:0] grf);
        if (s == 2'd1) return E_Fwd;
        if (s == 2'd2) return M_Fwd;
        return grf;
    endfunction

    vec_t vecs[12];

    initial begin
        logic [31:0] r, e1, e2, e_pcb, e_pcj;
        logic [5:0]  op;
        logic [4:0]  ra, rb;
        logic        e_br, e_jp;
        int          off;

        // Register state during the table: $1=7, $2=7, $5=0x1234, $31=0x3abc
        vecs[0]  = mk("bne_eq",       32'h1422_FFFF, 32'h3000, 0, 0, 0, 0,
                      7, 7, 0, 0, 32'h3000, 0, 0);
        vecs[1]  = mk("bne_fwd_e",    32'h1422_FFFF, 32'h3000, 1, 0, 9, 0,
                      9, 7, 1, 0, 32'h3000, 0, 0);
        vecs[2]  = mk("jal",          32'h0C00_0100, 32'h3004, 0, 0, 0, 0,
                      0, 0, 0, 1, 32'h3408, 32'h0000_0400, 1);
        vecs[3]  = mk("jr_fwd_m",     32'h03E0_0008, 32'h3008, 2, 0, 0, 32'h3ff0,
                      32'h3ff0, 0, 0, 1, 32'h302C, 32'h3ff0, 1);
        vecs[4]  = mk("jr_grf",       32'h03E0_0008, 32'h3008, 0, 0, 0, 0,
                      32'h3abc, 0, 0, 1, 32'h302C, 32'h3abc, 1);
        vecs[5]  = mk("jr_sel3",      32'h03E0_0008, 32'h3008, 3, 0, 1, 32'h3ff0,
                      32'h3abc, 0, 0, 1, 32'h302C, 32'h3abc, 1);
        vecs[6]  = mk("j_upper_pc",   32'h0BFF_FFFF, 32'hA000_0000, 0, 0, 0, 0,
                      32'h3abc, 32'h3abc, 0, 1, 32'hA000_0000, 32'hAFFF_FFFC, 1);
        vecs[7]  = mk("beq_wrap_dn",  32'h1000_8000, 32'h0000_0000, 0, 0, 0, 0,
                      0, 0, 1, 0, 32'hFFFE_0004, 0, 0);
        vecs[8]  = mk("bne_wrap_up",  32'h1420_7FFF, 32'hFFFF_FFF0, 0, 0, 0, 0,
                      7, 0, 1, 0, 32'h0001_FFF0, 0, 0);
        vecs[9]  = mk("beq_rt_fwd",   32'h1025_0001, 32'h3000, 0, 1, 7, 0,
                      7, 7, 1, 0, 32'h3008, 0, 0);
        vecs[10] = mk("beq_rt_sel3",  32'h1025_0001, 32'h3000, 0, 3, 7, 7,
                      7, 32'h1234, 0, 0, 32'h3008, 0, 0);
        vecs[11] = mk("jalr_not_jr",  32'h03E0_0009, 32'h3000, 0, 0, 0, 0,
                      32'h3abc, 0, 0, 0, 32'h3028, 0, 0);

        reset = 1'b1; stall = 1'b0; clr = 1'b0; F_Instr = 0; F_Pc = 0;
        W_WE = 1'b0; W_A3 = 0; W_WD = 0; FwdRsSel = 0; FwdRtSel = 0; E_Fwd = 0; M_Fwd = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_instr", D_Instr, 32'h0);
        chk("rst_pc", D_Pc, 32'h3000);

        // Asynchronous reset mid-cycle while writing and stalling
        step();
        wr(5'd3, 32'hdead);
        load(32'h0060_0008, 32'h3100);
        @(negedge clk);
        chk("pre_rst_rd1", RD1, 32'hdead);
        chk("pre_rst_jump", {31'd0, Jump}, 1);
        step();
        W_WE = 1'b1; W_A3 = 5'd3; W_WD = 32'h5555; stall = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("arst_instr", D_Instr, 32'h0);
        chk("arst_pc", D_Pc, 32'h3000);
        chk("arst_rd1", RD1, 32'h0);
        chk("arst_rd2", RD2, 32'h0);
        chk("arst_branch", {31'd0, Branch}, 0);
        chk("arst_jump", {31'd0, Jump}, 0);
        step();
        W_WE = 1'b0; stall = 1'b0; reset = 1'b0;
        load(32'h0060_0008, 32'h3100);
        @(negedge clk);
        chk("grf_cleared", RD1, 32'h0);

        step();
        wr(5'd1, 32'd7);
        wr(5'd2, 32'd7);
        wr(5'd31, 32'h3abc);

        // Same-cycle write bypass feeding a beq
        load(32'h10A5_0003, 32'h3010);
        W_WE = 1'b1; W_A3 = 5'd5; W_WD = 32'h1234;
        @(negedge clk);
        chk("byp_rd1", RD1, 32'h1234);
        chk("byp_rd2", RD2, 32'h1234);
        chk("byp_branch", {31'd0, Branch}, 1);
        chk("byp_pcb", PCBranch, 32'h3020);
        step();
        W_WE = 1'b0;

        foreach (vecs[i]) begin
            FwdRsSel = vecs[i].rs_sel; FwdRtSel = vecs[i].rt_sel;
            E_Fwd = vecs[i].e_fwd; M_Fwd = vecs[i].m_fwd;
            load(vecs[i].instr, vecs[i].pc);
            @(negedge clk);
            chk({vecs[i].name, "_rd1"}, RD1, vecs[i].rd1);
            chk({vecs[i].name, "_rd2"}, RD2, vecs[i].rd2);
            chk({vecs[i].name, "_br"}, {31'd0, Branch}, {31'd0, vecs[i].br});
            chk({vecs[i].name, "_jp"}, {31'd0, Jump}, {31'd0, vecs[i].jp});
            chk({vecs[i].name, "_pcb"}, PCBranch, vecs[i].pcb);
            if (vecs[i].chk_pcj) chk({vecs[i].name, "_pcj"}, PCJump, vecs[i].pcj);
        end
        FwdRsSel = 0; FwdRtSel = 0;

        // Stall holds IF/ID and suppresses Jump/Branch
        load(32'h0C00_0100, 32'h3004);
        @(negedge clk);
        chk("stl_jump_pre", {31'd0, Jump}, 1);
        step();
        stall = 1'b1; F_Instr = 32'h1000_0000; F_Pc = 32'h4000;
        @(negedge clk);
        chk("stl_jump0", {31'd0, Jump}, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("stl_hold_instr", D_Instr, 32'h0C00_0100);
            chk("stl_hold_pc", D_Pc, 32'h3004);
            chk("stl_jump", {31'd0, Jump}, 0);
        end
        step();
        stall = 1'b0;
        @(negedge clk);
        chk("unstl_jump", {31'd0, Jump}, 1);
        step();
        @(negedge clk);
        chk("unstl_load_pc", D_Pc, 32'h4000);
        chk("beq00_branch", {31'd0, Branch}, 1);
        step();
        stall = 1'b1;
        @(negedge clk);
        chk("beq_stl_branch", {31'd0, Branch}, 0);
        step();
        stall = 1'b0;

        // Register 0 ignores writes, including the same-cycle bypass
        load(32'h0000_0008, 32'h3000);
        W_WE = 1'b1; W_A3 = 5'd0; W_WD = 32'hffff_ffff;
        @(negedge clk);
        chk("r0_bypass", RD1, 32'h0);
        step();
        W_WE = 1'b0;
        @(negedge clk);
        chk("r0_after", RD1, 32'h0);

        // clr together with stall: clr wins
        step();
        load(32'h0C00_0100, 32'h3004);
        F_Pc = 32'h3008; clr = 1'b1; stall = 1'b1;
        step();
        clr = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("clr_instr", D_Instr, 32'h0);
        chk("clr_pc", D_Pc, 32'h3008);
        chk("clr_branch", {31'd0, Branch}, 0);
        chk("clr_jump", {31'd0, Jump}, 0);
        step();
        F_Pc = 32'h3100; clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_only_instr", D_Instr, 32'h0);
        chk("clr_only_pc", D_Pc, 32'h3100);

        // Randomized run against the model
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_instr = 32'h0;
        m_pc    = 32'h3000;

        for (int it = 0; it < 400; it++) begin
            r  = $urandom();
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: F_Instr = {6'b000100, ra, rb, r[15:0]};
                1: F_Instr = {6'b000101, ra, rb, r[15:0]};
                2: F_Instr = {6'b000010, r[25:0]};
                3: F_Instr = {6'b000011, r[25:0]};
                4: F_Instr = {6'b000000, ra, rb, r[15:6], 6'b001000};
                default: begin
                    op = 6'($urandom_range(0, 63));
                    F_Instr = {op, ra, rb, r[15:0]};
                end
            endcase
            F_Pc     = $urandom();
            stall    = ($urandom_range(0, 4) == 0);
            clr      = ($urandom_range(0, 9) == 0);
            W_WE     = $urandom_range(0, 1) == 1;
            W_A3     = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            W_WD     = ($urandom_range(0, 1) == 1) ? 32'd7 : $urandom();
            FwdRsSel = 2'($urandom_range(0, 3));
            FwdRtSel = 2'($urandom_range(0, 3));
            E_Fwd    = ($urandom_range(0, 1) == 1) ? 32'd7 : $urandom();
            M_Fwd    = $urandom();

            @(negedge clk);
            e1   = m_sel(FwdRsSel, m_read(m_instr[25:21]));
            e2   = m_sel(FwdRtSel, m_read(m_instr[20:16]));
            op   = m_instr[31:26];
            e_br = !stall && ((op == 6'd4 && e1 == e2) || (op == 6'd5 && e1 != e2));
            e_jp = !stall && (op == 6'd2 || op == 6'd3 || (op == 6'd0 && m_instr[5:0] == 6'd8));
            off  = $signed(m_instr[15:0]);
            e_pcb = m_pc + 32'd4 + 32'(off * 4);
            if (op == 6'd0) e_pcj = e1;
            else            e_pcj = (m_pc & 32'hF000_0000) + 32'(m_instr[25:0]) * 4;
            chk("rnd_instr", D_Instr, m_instr);
            chk("rnd_pc", D_Pc, m_pc);
            chk("rnd_rd1", RD1, e1);
            chk("rnd_rd2", RD2, e2);
            chk("rnd_branch", {31'd0, Branch}, {31'd0, e_br});
            chk("rnd_jump", {31'd0, Jump}, {31'd0, e_jp});
            chk("rnd_pcb", PCBranch, e_pcb);
            if (e_jp) chk("rnd_pcj", PCJump, e_pcj);

            @(posedge clk);
            if (clr) begin
                m_instr = 32'h0;
                m_pc    = F_Pc;
            end else if (!stall) begin
                m_instr = F_Instr;
                m_pc    = F_Pc;
            end
            if (W_WE && W_A3 != 0) m_regs[W_A3] = W_WD;
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
